// File: rtl/dlx_pkg.sv
// Shared definitions for the DLX fetch-stage branch target buffer:
// direction-counter encodings, default entry layout and the counter step.
package dlx_pkg;

    localparam logic [1:0] CTR_SNT = 2'b00;
    localparam logic [1:0] CTR_WNT = 2'b01;
    localparam logic [1:0] CTR_WT  = 2'b10;
    localparam logic [1:0] CTR_ST  = 2'b11;

    localparam int unsigned BTB_XLEN    = 32;
    localparam int unsigned BTB_ENTRIES = 16;
    localparam int unsigned BTB_IDX_W   = $clog2(BTB_ENTRIES);
    localparam int unsigned BTB_TAG_W   = BTB_XLEN - BTB_IDX_W - 2;

    // Entry layout for the default configuration.
    typedef struct packed {
        logic                   valid;
        logic [BTB_TAG_W-1:0]   tag;
        logic [BTB_XLEN-1:0]    target;
        logic [1:0]             ctr;
        logic                   jmp;
    } btb_entry_t;

    function automatic logic [1:0] sat_update(input logic [1:0] ctr, input logic taken);
        logic [1:0] nxt;
        nxt = ctr;
        if (taken) begin
            if (ctr != CTR_ST) nxt = ctr + 2'd1;
        end else begin
            if (ctr != CTR_SNT) nxt = ctr - 2'd1;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/dlx_branch_predictor.sv
// Direct-mapped BTB with 2-bit direction counters: zero-latency lookup of the
// fetch PC, registered learning from resolved branches/jumps, mispredict stats.
module dlx_branch_predictor
    import dlx_pkg::*;
#(
    parameter int unsigned XLEN    = 32,
    parameter int unsigned ENTRIES = 16,
    parameter int unsigned CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [XLEN-1:0]  fetch_pc,
    output logic [XLEN-1:0]  pred_next_pc,
    output logic             pred_taken,
    output logic             pred_hit,
    input  logic             upd_valid,
    input  logic [XLEN-1:0]  upd_pc,
    input  logic             upd_is_jump,
    input  logic             upd_taken,
    input  logic [XLEN-1:0]  upd_target,
    input  logic             upd_mispredict,
    input  logic             inv,
    output logic [CNT_W-1:0] mispred_count
);

    localparam int unsigned IDX_W = $clog2(ENTRIES);
    localparam int unsigned TAG_W = XLEN - IDX_W - 2;

    typedef struct packed {
        logic               valid;
        logic [TAG_W-1:0]   tag;
        logic [XLEN-1:0]    target;
        logic [1:0]         ctr;
        logic               jmp;
    } entry_t;

    entry_t             r_table [ENTRIES];
    logic [CNT_W-1:0]   r_mispred_cnt;

    logic [IDX_W-1:0]   w_fidx;
    logic [TAG_W-1:0]   w_ftag;
    logic [IDX_W-1:0]   w_uidx;
    logic [TAG_W-1:0]   w_utag;
    entry_t             w_fent;
    entry_t             w_uent;
    logic               w_fhit;
    logic               w_ftaken;
    logic               w_uhit;
    logic               w_unused;

    assign w_fidx   = fetch_pc[IDX_W+1:2];
    assign w_ftag   = fetch_pc[XLEN-1:IDX_W+2];
    assign w_uidx   = upd_pc[IDX_W+1:2];
    assign w_utag   = upd_pc[XLEN-1:IDX_W+2];
    assign w_unused = &{1'b0, fetch_pc[1:0], upd_pc[1:0]};

    // Lookup reads the registered table, so a same-cycle update is not seen.
    always_comb begin
        w_fent   = r_table[w_fidx];
        w_uent   = r_table[w_uidx];
        w_fhit   = w_fent.valid && (w_fent.tag == w_ftag);
        w_ftaken = w_fhit && (w_fent.jmp || w_fent.ctr[1]);
        w_uhit   = w_uent.valid && (w_uent.tag == w_utag);
    end

    assign pred_hit      = w_fhit;
    assign pred_taken    = w_ftaken;
    assign pred_next_pc  = w_ftaken ? w_fent.target : fetch_pc + XLEN'(4);
    assign mispred_count = r_mispred_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < ENTRIES; i++) begin
                r_table[i[IDX_W-1:0]].valid  <= 1'b0;
                r_table[i[IDX_W-1:0]].tag    <= '0;
                r_table[i[IDX_W-1:0]].target <= '0;
                r_table[i[IDX_W-1:0]].ctr    <= CTR_WNT;
                r_table[i[IDX_W-1:0]].jmp    <= 1'b0;
            end
            r_mispred_cnt <= '0;
        end else begin
            if (upd_valid && upd_mispredict && (r_mispred_cnt != '1))
                r_mispred_cnt <= r_mispred_cnt + 1'b1;

            if (inv) begin
                for (int unsigned i = 0; i < ENTRIES; i++)
                    r_table[i[IDX_W-1:0]].valid <= 1'b0;
            end else if (upd_valid) begin
                if (w_uhit) begin
                    r_table[w_uidx].ctr <= upd_is_jump ? CTR_ST : sat_update(w_uent.ctr, upd_taken);
                    r_table[w_uidx].jmp <= upd_is_jump;
                    if (upd_taken)
                        r_table[w_uidx].target <= upd_target;
                end else if (upd_taken) begin
                    // Allocation overwrites whatever entry aliases at this index.
                    r_table[w_uidx].valid  <= 1'b1;
                    r_table[w_uidx].tag    <= w_utag;
                    r_table[w_uidx].target <= upd_target;
                    r_table[w_uidx].ctr    <= upd_is_jump ? CTR_ST : CTR_WT;
                    r_table[w_uidx].jmp    <= upd_is_jump;
                end
            end
        end
    end

endmodule

// File: tb/tb_dlx_branch_predictor.sv
// Directed table-driven bench for dlx_branch_predictor (16 entries, 4-bit stats).
module tb_dlx_branch_predictor;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] fetch_pc;
    logic [31:0] pred_next_pc;
    logic        pred_taken;
    logic        pred_hit;
    logic        upd_valid;
    logic [31:0] upd_pc;
    logic        upd_is_jump;
    logic        upd_taken;
    logic [31:0] upd_target;
    logic        upd_mispredict;
    logic        inv;
    logic [3:0]  mispred_count;

    int unsigned n_pass = 0;
    int unsigned n_total = 0;

    dlx_branch_predictor #(.XLEN(32), .ENTRIES(16), .CNT_W(4)) dut (
        .clk            (clk),
        .rst            (rst),
        .fetch_pc       (fetch_pc),
        .pred_next_pc   (pred_next_pc),
        .pred_taken     (pred_taken),
        .pred_hit       (pred_hit),
        .upd_valid      (upd_valid),
        .upd_pc         (upd_pc),
        .upd_is_jump    (upd_is_jump),
        .upd_taken      (upd_taken),
        .upd_target     (upd_target),
        .upd_mispredict (upd_mispredict),
        .inv            (inv),
        .mispred_count  (mispred_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        uv;
        logic [31:0] upc;
        logic        ujmp;
        logic        utk;
        logic [31:0] utgt;
        logic        umis;
        logic        inv;
        logic [31:0] fpc;
        logic        e_hit;
        logic        e_tk;
        logic [31:0] e_npc;
        logic [3:0]  e_cnt;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic uv, input logic [31:0] upc, input logic ujmp,
                                input logic utk, input logic [31:0] utgt, input logic umis,
                                input logic iv, input logic [31:0] fpc, input logic e_hit,
                                input logic e_tk, input logic [31:0] e_npc, input logic [3:0] e_cnt);
        vec_t v;
        v.uv = uv; v.upc = upc; v.ujmp = ujmp; v.utk = utk; v.utgt = utgt; v.umis = umis;
        v.inv = iv; v.fpc = fpc; v.e_hit = e_hit; v.e_tk = e_tk; v.e_npc = e_npc; v.e_cnt = e_cnt;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    endtask

    task automatic check_outs(input string tag, input logic e_hit, input logic e_tk,
                              input logic [31:0] e_npc, input logic [3:0] e_cnt);
        chk({tag, " hit"},    32'(pred_hit),      32'(e_hit));
        chk({tag, " taken"},  32'(pred_taken),    32'(e_tk));
        chk({tag, " nextpc"}, pred_next_pc,       e_npc);
        chk({tag, " cnt"},    32'(mispred_count), 32'(e_cnt));
    endtask

    task automatic idle_inputs();
        upd_valid = 1'b0; upd_pc = '0; upd_is_jump = 1'b0; upd_taken = 1'b0;
        upd_target = '0; upd_mispredict = 1'b0; inv = 1'b0;
    endtask

    initial begin
        // Expected outputs are the lookup before this row's own update takes effect.
        //               uv upc       jmp tk tgt          mis inv fpc           hit tk npc          cnt
        vecs.push_back(mk(0, 32'h000, 0, 0, 32'h000, 0, 0, 32'h100,      0, 0, 32'h104,      0));
        vecs.push_back(mk(1, 32'h100, 0, 1, 32'h200, 1, 0, 32'h100,      0, 0, 32'h104,      0));
        vecs.push_back(mk(1, 32'h100, 0, 0, 32'h000, 1, 0, 32'h100,      1, 1, 32'h200,      1));
        vecs.push_back(mk(1, 32'h100, 0, 0, 32'h000, 0, 0, 32'h100,      1, 0, 32'h104,      2));
        vecs.push_back(mk(1, 32'h100, 0, 1, 32'h200, 0, 0, 32'h100,      1, 0, 32'h104,      2));
        vecs.push_back(mk(0, 32'h000, 0, 0, 32'h000, 0, 0, 32'h100,      1, 0, 32'h104,      2));
        vecs.push_back(mk(0, 32'h000, 0, 0, 32'h000, 0, 0, 32'h140,      0, 0, 32'h144,      2));
        vecs.push_back(mk(1, 32'h140, 0, 1, 32'h300, 1, 0, 32'h140,      0, 0, 32'h144,      2));
        vecs.push_back(mk(0, 32'h000, 0, 0, 32'h000, 0, 0, 32'h100,      0, 0, 32'h104,      3));
        vecs.push_back(mk(0, 32'h000, 0, 0, 32'h000, 0, 0, 32'h140,      1, 1, 32'h300,      3));
        vecs.push_back(mk(1, 32'h080, 1, 1, 32'h400, 0, 0, 32'h080,      0, 0, 32'h084,      3));
        vecs.push_back(mk(0, 32'h000, 0, 0, 32'h000, 0, 0, 32'h080,      1, 1, 32'h400,      3));
        vecs.push_back(mk(1, 32'h080, 1, 1, 32'h500, 0, 0, 32'h080,      1, 1, 32'h400,      3));
        vecs.push_back(mk(0, 32'h000, 0, 0, 32'h000, 0, 0, 32'h080,      1, 1, 32'h500,      3));
        vecs.push_back(mk(1, 32'h080, 0, 0, 32'h000, 0, 0, 32'h080,      1, 1, 32'h500,      3));
        vecs.push_back(mk(0, 32'h000, 0, 0, 32'h000, 0, 0, 32'h080,      1, 1, 32'h500,      3));
        vecs.push_back(mk(1, 32'h080, 0, 0, 32'h000, 0, 0, 32'h080,      1, 1, 32'h500,      3));
        vecs.push_back(mk(0, 32'h000, 0, 0, 32'h000, 0, 0, 32'h080,      1, 0, 32'h084,      3));
        vecs.push_back(mk(1, 32'h240, 0, 0, 32'h000, 0, 0, 32'h080,      1, 0, 32'h084,      3));
        vecs.push_back(mk(0, 32'h000, 0, 0, 32'h000, 0, 0, 32'h080,      1, 0, 32'h084,      3));
        vecs.push_back(mk(0, 32'h000, 0, 0, 32'h000, 0, 0, 32'h240,      0, 0, 32'h244,      3));
        vecs.push_back(mk(1, 32'h204, 0, 1, 32'h600, 0, 0, 32'h204,      0, 0, 32'h208,      3));
        vecs.push_back(mk(0, 32'h000, 0, 0, 32'h000, 0, 0, 32'h204,      1, 1, 32'h600,      3));
        vecs.push_back(mk(1, 32'h200, 0, 1, 32'h700, 0, 1, 32'h200,      0, 0, 32'h204,      3));
        vecs.push_back(mk(0, 32'h000, 0, 0, 32'h000, 0, 0, 32'h200,      0, 0, 32'h204,      3));
        vecs.push_back(mk(0, 32'h000, 0, 0, 32'h000, 1, 0, 32'h204,      0, 0, 32'h208,      3));
        vecs.push_back(mk(0, 32'h000, 0, 0, 32'h000, 0, 0, 32'h080,      0, 0, 32'h084,      3));
        vecs.push_back(mk(0, 32'h000, 0, 0, 32'h000, 0, 0, 32'hFFFFFFFC, 0, 0, 32'h00000000, 3));

        idle_inputs();
        rst = 1'b1;
        fetch_pc = 32'h100;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_outs("in_reset", 1'b0, 1'b0, 32'h104, 4'd0);
        rst = 1'b0;

        foreach (vecs[i]) begin
            @(negedge clk);
            upd_valid = vecs[i].uv; upd_pc = vecs[i].upc; upd_is_jump = vecs[i].ujmp;
            upd_taken = vecs[i].utk; upd_target = vecs[i].utgt; upd_mispredict = vecs[i].umis;
            inv = vecs[i].inv; fetch_pc = vecs[i].fpc;
            #1;
            check_outs($sformatf("vec%0d", i), vecs[i].e_hit, vecs[i].e_tk, vecs[i].e_npc, vecs[i].e_cnt);
        end

        // Stats counter saturation: 20 more mispredicts on a not-taken miss.
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            idle_inputs();
            upd_valid = 1'b1; upd_pc = 32'h1000; upd_mispredict = 1'b1;
        end
        @(negedge clk);
        idle_inputs();
        fetch_pc = 32'h1000;
        #1;
        chk("cnt_saturated", 32'(mispred_count), 32'd15);
        chk("nt_miss_no_alloc", 32'(pred_hit), 32'd0);

        @(negedge clk);
        inv = 1'b1;
        @(negedge clk);
        inv = 1'b0;
        #1;
        chk("cnt_after_inv", 32'(mispred_count), 32'd15);

        // Reset asserted with a pending taken update: update must be discarded.
        @(negedge clk);
        rst = 1'b1;
        upd_valid = 1'b1; upd_pc = 32'h300; upd_taken = 1'b1; upd_target = 32'h800; upd_mispredict = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        idle_inputs();
        fetch_pc = 32'h300;
        #1;
        check_outs("post_reset", 1'b0, 1'b0, 32'h304, 4'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/dlx_branch_predictor.md
Name: dlx_branch_predictor

Overview:
Parametrised fetch-stage branch target buffer (BTB) for the pipelined DLX core. Each entry holds a 2-bit saturating direction counter.
- Replaces the fixed PC+4 next-PC path. Each cycle it supplies a predicted next PC for the fetch address.
- Learns from branch/J/JR outcomes resolved later in the pipeline.
- Counts mispredictions for performance monitoring.

Parameters:
XLEN, 32, address and data width in bits.
ENTRIES, 16, number of BTB entries; must be a power of two, ≥2.
CNT_W, 16, width of the mispredict statistics counter.
Derived: IDX_W = log2(ENTRIES); TAG_W = XLEN - IDX_W - 2.

Ports:
clk  in  1  system clock; all state updates on its rising edge.
rst  in  1  synchronous, active-high reset.
fetch_pc  in  XLEN  current fetch address; word aligned.
pred_next_pc  out  XLEN  predicted next fetch address.
pred_taken  out  1  lookup hit with a taken prediction.
pred_hit  out  1  lookup hit (valid entry, tag match).
upd_valid  in  1  resolved control-transfer update present this cycle.
upd_pc  in  XLEN  address of the resolved instruction.
upd_is_jump  in  1  resolved instruction is J or JR (unconditional).
upd_taken  in  1  resolved outcome was taken.
upd_target  in  XLEN  resolved target address.
upd_mispredict  in  1  pipeline flushed because of this instruction's prediction.
inv  in  1  invalidate the whole table (context switch or self-modifying code).
mispred_count  out  CNT_W  saturating count of mispredictions.

Behaviour:
- Address split: index = pc[IDX_W+1:2], tag = pc[XLEN-1:IDX_W+2]. pc[1:0] is ignored.
- Entry fields: valid, tag[TAG_W], target[XLEN], ctr[2], jmp.
- Lookup is combinational, from fetch_pc to the outputs, with zero latency:
  - pred_hit = valid & tag match.
  - pred_taken = pred_hit & (jmp | ctr[1]).
  - pred_next_pc = pred_taken ? target : fetch_pc + 4. The +4 addition wraps modulo 2^XLEN.
- Counter encoding: 00 strong-NT, 01 weak-NT, 10 weak-T, 11 strong-T. Increments saturate at 11; decrements saturate at 00.
- Update is registered; the table write is visible to lookup on the cycle after upd_valid.
  - Update hit (valid & tag match at index(upd_pc)):
    - Branch: ctr moves ±1 according to upd_taken.
    - Taken: target <= upd_target.
    - jmp <= upd_is_jump; a jump forces ctr to 11.
  - Update miss, taken: allocate, overwriting any aliased entry.
    - valid=1, tag, target, jmp=upd_is_jump.
    - ctr=10 for a branch, 11 for a jump.
  - Update miss, not taken: table unchanged.
- Lookup and update in the same cycle at the same index: lookup returns the pre-update contents.
- inv: all valid bits clear on the next edge. inv overrides an upd_valid in the same cycle; that update is dropped.
- mispred_count increments when upd_valid & upd_mispredict, and saturates at 2^CNT_W-1. It is not cleared by inv.
- Reset:
  - All valid=0, ctr=01, jmp=0, tag=0, target=0; mispred_count=0.
  - Hence during and after reset: pred_hit=0, pred_taken=0, pred_next_pc=fetch_pc+4.
  - Reset overrides inv and upd_valid.
  - Reset mid-operation discards the pending update; there is no partial write.
- upd_valid=0: no state change except as specified for inv and rst.
- Inputs are sampled only on clock edges. There is no handshake and the block never stalls.

Decomposition:
- dlx_pkg:
  - Counter encoding constants: CTR_SNT, CTR_WNT, CTR_WT, CTR_ST.
  - A BTB entry struct typedef parametrised by TAG_W/XLEN via localparams.
  - Helper function sat_update(ctr, taken).
- Sub-module dlx_sat_counter2: a 2-bit saturating up/down counter with force-ST input, instantiated ENTRIES times via generate. Alternatively the table is flat arrays and the counter logic is the package function.
- The top level holds the index/tag decode, the lookup mux, the update/allocate logic and the stats counter.

Test Plan:
- Reset then fetch_pc=0x100 -> pred_hit=0, pred_taken=0, pred_next_pc=0x104, mispred_count=0.
- Update pc=0x100, branch, taken, target=0x200, mispredict=1 -> next cycle lookup 0x100 gives hit=1, taken=1, next_pc=0x200, ctr=10, mispred_count=1.
- Two more not-taken updates at 0x100 -> after first: ctr=01, taken=0, next_pc=0x104, hit=1; after second: ctr=00. Third taken update -> ctr=01, still predict NT.
- ENTRIES=16: entry allocated for 0x100 (idx 0, tag 4); lookup 0x140 (idx 0, tag 5) -> hit=0, next_pc=0x144. Taken update at 0x140 target 0x300 evicts the entry: lookup 0x100 misses, lookup 0x140 gives 0x300.
- Jump: update 0x80, is_jump=1, taken, target 0x400, then four not-taken branch-type updates are not issued. Lookup 0x80 -> taken=1, 0x400. Same-cycle lookup+update at 0x80 with new target 0x500 -> that cycle 0x400, next cycle 0x500.
- inv asserted together with a taken update at 0x200 -> next cycle all lookups miss, including 0x200. With CNT_W=4, 20 mispredict updates -> mispred_count=15, unchanged by inv and cleared only by rst.
